// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory arbiter: FSM states, access owner, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in;
  logic              mem_write_n;
  logic              mem_read_n;
  logic [DATA_W-1:0] mem_out;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_out,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_in, mem_write_n, mem_read_n, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_out,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
           mem_addr, mem_in, mem_write_n, mem_read_n, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational 2-way pick between IF and LS; zero latency, at most one grant.
// On contention: FAIR!=0 alternates against last_owner, FAIR==0 always favours LS.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic   if_req,
  input  logic   ls_req,
  input  owner_t last_owner,
  output logic   grant_if,
  output logic   grant_ls
);

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (if_req && ls_req) begin
      if ((FAIR != 0) && (last_owner == OWN_LS)) begin
        grant_if = 1'b1;
      end else begin
        grant_ls = 1'b1;
      end
    end else begin
      grant_if = if_req;
      grant_ls = ls_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between IF (read) and LS (read/write); gnt in N, strobe in N+1, rvalid in N+2.
// Requests are held until gnt; at most one access every 2 cycles, requests seen during ACC wait for RSP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int FAIR   = 1
) (
  input  logic          clk,
  input  logic          proc_rst,
  mem_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            last_owner;
  owner_t            pick_owner;
  logic              grant_if;
  logic              grant_ls;
  logic              accept;
  logic              acc_we;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic [DATA_W-1:0] capture;
  logic              write_n_q;
  logic              read_n_q;
  logic              if_rvalid_q;
  logic              ls_rvalid_q;

  mem_arb_pick #(.FAIR(FAIR)) u_pick (
    .if_req     (bus.if_req),
    .ls_req     (bus.ls_req),
    .last_owner (last_owner),
    .grant_if   (grant_if),
    .grant_ls   (grant_ls)
  );

  assign pick_owner = grant_ls ? OWN_LS : OWN_IF;
  // Writes echo the data that was driven to the memory instead of reading it back.
  assign capture    = acc_we ? wdata_q : bus.mem_out;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, RSP: begin
        if (bus.if_req || bus.ls_req) begin
          accept    = 1'b1;
          state_nxt = ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC:     state_nxt = RSP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!proc_rst) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      last_owner  <= OWN_IF;
      acc_we      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state       <= state_nxt;
      write_n_q   <= 1'b1;
      read_n_q    <= 1'b1;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if (accept) begin
        owner      <= pick_owner;
        last_owner <= pick_owner;
        acc_we     <= grant_ls && bus.ls_we;
        addr_q     <= grant_ls ? bus.ls_addr : bus.if_addr;
        if (grant_ls) begin
          wdata_q <= bus.ls_wdata;
        end
        if (grant_ls && bus.ls_we) begin
          write_n_q <= 1'b0;
        end else begin
          read_n_q <= 1'b0;
        end
      end
      if (state == ACC) begin
        if (owner == OWN_LS) begin
          ls_rdata_q  <= capture;
          ls_rvalid_q <= 1'b1;
        end else begin
          if_rdata_q  <= capture;
          if_rvalid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.if_gnt      = accept && grant_if;
  assign bus.ls_gnt      = accept && grant_ls;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.ls_rvalid   = ls_rvalid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.ls_rdata    = ls_rdata_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_in      = wdata_q;
  assign bus.mem_write_n = write_n_q;
  assign bus.mem_read_n  = read_n_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: FAIR=1 and FAIR=0 instances, each with a behavioural 32x16 memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic proc_rst;
  logic preload;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bf ();
  mem_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bp ();

  mem_arbiter #(.ADDR_W(5), .DATA_W(16), .FAIR(1)) dut (
    .clk(clk), .proc_rst(proc_rst), .bus(bf.slave)
  );
  mem_arbiter #(.ADDR_W(5), .DATA_W(16), .FAIR(0)) dut_p (
    .clk(clk), .proc_rst(proc_rst), .bus(bp.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_f [32];
  logic [15:0] mem_p [32];
  logic [15:0] ref_mem [32];

  function automatic logic [15:0] init_val(int i);
    if (i == 0) return 16'h02F0;
    if (i == 1) return 16'h22E8;
    return 16'hA000 + 16'(i) * 16'h0111;
  endfunction

  // Memory acts on the falling edge of the strobed cycle.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_f[i] <= init_val(i);
    end else begin
      if (!bf.mem_write_n) mem_f[bf.mem_addr] <= bf.mem_in;
      if (!bf.mem_read_n)  bf.mem_out <= mem_f[bf.mem_addr];
    end
  end

  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem_p[i] <= init_val(i);
    end else begin
      if (!bp.mem_write_n) mem_p[bp.mem_addr] <= bp.mem_in;
      if (!bp.mem_read_n)  bp.mem_out <= mem_p[bp.mem_addr];
    end
  end

  task automatic drive_idle();
    bf.if_req = 0; bf.if_addr = 0; bf.ls_req = 0; bf.ls_we = 0; bf.ls_addr = 0; bf.ls_wdata = 0;
    bp.if_req = 0; bp.if_addr = 0; bp.ls_req = 0; bp.ls_we = 0; bp.ls_addr = 0; bp.ls_wdata = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [59:0] obs;
    logic [59:0] exp_v;
    drive_idle();
    proc_rst = 0;
    preload  = 1;
    repeat (3) @(posedge clk);
    #1;
    preload = 0;
    exp_v = {1'b1, 1'b1, 5'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0};
    obs = {bf.mem_write_n, bf.mem_read_n, bf.mem_addr, bf.mem_in, bf.if_rvalid, bf.ls_rvalid,
           bf.if_rdata, bf.ls_rdata, bf.busy, bf.if_gnt, bf.ls_gnt};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_fair: got %h want %h", obs, exp_v); end
    obs = {bp.mem_write_n, bp.mem_read_n, bp.mem_addr, bp.mem_in, bp.if_rvalid, bp.ls_rvalid,
           bp.if_rdata, bp.ls_rdata, bp.busy, bp.if_gnt, bp.ls_gnt};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_prio: got %h want %h", obs, exp_v); end
    proc_rst = 1;
    next_cycle();
  endtask

  task automatic test_if_read();
    logic [15:0] exp_d [2];
    exp_d[0] = 16'h02F0;
    exp_d[1] = 16'h22E8;
    for (int a = 0; a < 2; a++) begin
      bf.if_req = 1; bf.if_addr = 5'(a);
      @(negedge clk);
      total++;
      if ({bf.if_gnt, bf.ls_gnt} !== 2'b10) begin
        bad++; $display("FAIL if_read_gnt a=%0d: got %b want 10", a, {bf.if_gnt, bf.ls_gnt});
      end
      next_cycle();
      bf.if_req = 0;
      total++;
      if ({bf.mem_read_n, bf.mem_write_n, bf.mem_addr, bf.busy} !== {1'b0, 1'b1, 5'(a), 1'b1}) begin
        bad++; $display("FAIL if_read_strobe a=%0d: rn=%b wn=%b addr=%0d busy=%b", a,
                        bf.mem_read_n, bf.mem_write_n, bf.mem_addr, bf.busy);
      end
      next_cycle();
      total++;
      if ({bf.if_rvalid, bf.ls_rvalid, bf.if_rdata} !== {1'b1, 1'b0, exp_d[a]}) begin
        bad++; $display("FAIL if_read_data a=%0d: rv=%b lrv=%b data=%h want %h", a,
                        bf.if_rvalid, bf.ls_rvalid, bf.if_rdata, exp_d[a]);
      end
      next_cycle();
      total++;
      if ({bf.if_rvalid, bf.mem_read_n, bf.busy} !== 3'b010) begin
        bad++; $display("FAIL if_read_after a=%0d: got %b want 010", a,
                        {bf.if_rvalid, bf.mem_read_n, bf.busy});
      end
    end
  endtask

  task automatic test_write_read();
    bf.ls_req = 1; bf.ls_we = 1; bf.ls_addr = 5; bf.ls_wdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({bf.if_gnt, bf.ls_gnt} !== 2'b01) begin
      bad++; $display("FAIL wr_gnt: got %b want 01", {bf.if_gnt, bf.ls_gnt});
    end
    next_cycle();
    bf.ls_req = 0; bf.ls_we = 0;
    total++;
    if ({bf.mem_write_n, bf.mem_read_n, bf.mem_addr, bf.mem_in} !== {1'b0, 1'b1, 5'd5, 16'hBEEF}) begin
      bad++; $display("FAIL wr_strobe: wn=%b rn=%b addr=%0d in=%h", bf.mem_write_n, bf.mem_read_n,
                      bf.mem_addr, bf.mem_in);
    end
    next_cycle();
    total++;
    if ({bf.ls_rvalid, bf.ls_rdata, bf.mem_write_n, bf.if_rvalid} !== {1'b1, 16'hBEEF, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wr_ack: lrv=%b data=%h wn=%b irv=%b", bf.ls_rvalid, bf.ls_rdata,
                      bf.mem_write_n, bf.if_rvalid);
    end
    bf.if_req = 1; bf.if_addr = 5;
    @(negedge clk);
    total++;
    if ({bf.if_gnt, bf.ls_gnt} !== 2'b10) begin
      bad++; $display("FAIL rd_gnt_in_rsp: got %b want 10", {bf.if_gnt, bf.ls_gnt});
    end
    next_cycle();
    bf.if_req = 0;
    total++;
    if ({bf.mem_read_n, bf.mem_write_n, bf.mem_addr} !== {1'b0, 1'b1, 5'd5}) begin
      bad++; $display("FAIL rd_strobe: rn=%b wn=%b addr=%0d", bf.mem_read_n, bf.mem_write_n, bf.mem_addr);
    end
    next_cycle();
    total++;
    if ({bf.if_rvalid, bf.if_rdata, bf.ls_rvalid, bf.ls_rdata} !== {1'b1, 16'hBEEF, 1'b0, 16'hBEEF}) begin
      bad++; $display("FAIL rd_back: irv=%b idata=%h lrv=%b ldata=%h", bf.if_rvalid, bf.if_rdata,
                      bf.ls_rvalid, bf.ls_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    bf.ls_req = 1; bf.ls_we = 0; bf.ls_addr = 0;
    @(negedge clk);
    total++;
    if (bf.ls_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt0: got %b want 1", bf.ls_gnt); end
    next_cycle();
    bf.ls_addr = 1;
    @(negedge clk);
    total++;
    if ({bf.if_gnt, bf.ls_gnt} !== 2'b00) begin
      bad++; $display("FAIL b2b_no_gnt_acc: got %b want 00", {bf.if_gnt, bf.ls_gnt});
    end
    next_cycle();
    total++;
    if ({bf.ls_rvalid, bf.ls_rdata} !== {1'b1, 16'h02F0}) begin
      bad++; $display("FAIL b2b_data0: rv=%b data=%h want 02f0", bf.ls_rvalid, bf.ls_rdata);
    end
    @(negedge clk);
    total++;
    if (bf.ls_gnt !== 1'b1) begin bad++; $display("FAIL b2b_gnt1: got %b want 1", bf.ls_gnt); end
    next_cycle();
    bf.ls_req = 0;
    total++;
    if ({bf.ls_rvalid, bf.mem_read_n, bf.mem_addr} !== {1'b0, 1'b0, 5'd1}) begin
      bad++; $display("FAIL b2b_strobe1: rv=%b rn=%b addr=%0d", bf.ls_rvalid, bf.mem_read_n, bf.mem_addr);
    end
    next_cycle();
    total++;
    if ({bf.ls_rvalid, bf.ls_rdata} !== {1'b1, 16'h22E8}) begin
      bad++; $display("FAIL b2b_data1: rv=%b data=%h want 22e8", bf.ls_rvalid, bf.ls_rdata);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic [1:0] exp_f;
    logic [1:0] exp_p;
    proc_rst = 0;
    next_cycle();
    proc_rst = 1;
    bf.if_req = 1; bf.if_addr = 2; bf.ls_req = 1; bf.ls_we = 0; bf.ls_addr = 3;
    bp.if_req = 1; bp.if_addr = 2; bp.ls_req = 1; bp.ls_we = 0; bp.ls_addr = 3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_f = (k % 2 != 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
      exp_p = (k % 2 != 0) ? 2'b00 : 2'b01;
      total++;
      if ({bf.if_gnt, bf.ls_gnt} !== exp_f) begin
        bad++; $display("FAIL contend_fair k=%0d: got %b want %b", k, {bf.if_gnt, bf.ls_gnt}, exp_f);
      end
      total++;
      if ({bp.if_gnt, bp.ls_gnt} !== exp_p) begin
        bad++; $display("FAIL contend_prio k=%0d: got %b want %b", k, {bp.if_gnt, bp.ls_gnt}, exp_p);
      end
    end
    next_cycle();
    drive_idle();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    bf.ls_req = 1; bf.ls_we = 1; bf.ls_addr = 3; bf.ls_wdata = 16'h1234;
    @(negedge clk);
    total++;
    if (bf.ls_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt: got %b want 1", bf.ls_gnt); end
    next_cycle();
    bf.ls_req = 0; bf.ls_we = 0;
    total++;
    if (bf.mem_write_n !== 1'b0) begin bad++; $display("FAIL rstmid_acc: wn=%b want 0", bf.mem_write_n); end
    proc_rst = 0;
    next_cycle();
    proc_rst = 1;
    total++;
    if ({bf.mem_write_n, bf.mem_read_n, bf.ls_rvalid, bf.if_rvalid, bf.mem_addr, bf.mem_in,
         bf.if_rdata, bf.ls_rdata, bf.busy} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 16'd0, 16'd0, 1'b0}) begin
      bad++; $display("FAIL rstmid_outputs: wn=%b rn=%b lrv=%b irv=%b addr=%0d in=%h ird=%h lrd=%h busy=%b",
                      bf.mem_write_n, bf.mem_read_n, bf.ls_rvalid, bf.if_rvalid, bf.mem_addr,
                      bf.mem_in, bf.if_rdata, bf.ls_rdata, bf.busy);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      total++;
      if ({bf.ls_rvalid, bf.busy} !== 2'b00) begin
        bad++; $display("FAIL rstmid_quiet k=%0d: rv=%b busy=%b want 00", k, bf.ls_rvalid, bf.busy);
      end
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({bf.if_gnt, bf.ls_gnt} !== 2'b00) begin
        bad++; $display("FAIL idle_gnt k=%0d: got %b want 00", k, {bf.if_gnt, bf.ls_gnt});
      end
      next_cycle();
      total++;
      if ({bf.mem_write_n, bf.mem_read_n, bf.if_rvalid, bf.ls_rvalid, bf.busy} !== 5'b11000) begin
        bad++; $display("FAIL idle_state k=%0d: got %b want 11000", k,
                        {bf.mem_write_n, bf.mem_read_n, bf.if_rvalid, bf.ls_rvalid, bf.busy});
      end
    end
  endtask

  // Reference: an accept may happen once at least 2 cycles have passed since the last one;
  // its strobe appears one cycle later and the response one cycle after that.
  task automatic test_random();
    int          next_ok = 0;
    bit          last_ls = 0;
    bit          rec_valid = 0, rec_ls = 0, rec_we = 0;
    int          rec_acc = -10;
    logic [4:0]  rec_addr = 0;
    logic [15:0] rec_data = 0;
    logic [15:0] exp_ird = 0, exp_lrd = 0;
    bit          if_pend = 0, ls_pend = 0, ls_w = 0;
    logic [4:0]  if_a = 0, ls_a = 0;
    logic [15:0] ls_d = 0;
    bit          acc, win_ls, exp_rn, exp_wn, exp_irv, exp_lrv;
    logic [1:0]  exp_g;
    preload  = 1;
    proc_rst = 0;
    next_cycle();
    next_cycle();
    preload  = 0;
    proc_rst = 1;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    for (int c = 0; c < 400; c++) begin
      exp_rn  = !(rec_valid && c == rec_acc + 1 && !rec_we);
      exp_wn  = !(rec_valid && c == rec_acc + 1 && rec_we);
      exp_irv = rec_valid && c == rec_acc + 2 && !rec_ls;
      exp_lrv = rec_valid && c == rec_acc + 2 && rec_ls;
      if (exp_irv) exp_ird = rec_data;
      if (exp_lrv) exp_lrd = rec_data;
      total++;
      if ({bf.mem_read_n, bf.mem_write_n, bf.if_rvalid, bf.ls_rvalid, bf.if_rdata, bf.ls_rdata} !==
          {exp_rn, exp_wn, exp_irv, exp_lrv, exp_ird, exp_lrd}) begin
        bad++; $display("FAIL rand_resp c=%0d: rn/wn/irv/lrv=%b%b%b%b ird=%h lrd=%h want %b%b%b%b %h %h", c,
                        bf.mem_read_n, bf.mem_write_n, bf.if_rvalid, bf.ls_rvalid, bf.if_rdata,
                        bf.ls_rdata, exp_rn, exp_wn, exp_irv, exp_lrv, exp_ird, exp_lrd);
      end
      if (!exp_rn || !exp_wn) begin
        total++;
        if (bf.mem_addr !== rec_addr || (rec_we && bf.mem_in !== rec_data)) begin
          bad++; $display("FAIL rand_bus c=%0d: addr=%0d in=%h want addr=%0d in=%h", c,
                          bf.mem_addr, bf.mem_in, rec_addr, rec_data);
        end
      end
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_a = 5'($urandom_range(0, 31));
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1; ls_a = 5'($urandom_range(0, 31)); ls_w = 1'($urandom_range(0, 1));
        ls_d = 16'($urandom);
      end
      bf.if_req = if_pend; bf.if_addr = if_a;
      bf.ls_req = ls_pend; bf.ls_addr = ls_a; bf.ls_we = ls_w; bf.ls_wdata = ls_d;
      @(negedge clk);
      acc    = (c >= next_ok) && (if_pend || ls_pend);
      win_ls = ls_pend && (!if_pend || !last_ls);
      exp_g  = !acc ? 2'b00 : (win_ls ? 2'b01 : 2'b10);
      total++;
      if ({bf.if_gnt, bf.ls_gnt} !== exp_g) begin
        bad++; $display("FAIL rand_gnt c=%0d: got %b want %b", c, {bf.if_gnt, bf.ls_gnt}, exp_g);
      end
      if (acc) begin
        rec_valid = 1; rec_acc = c; rec_ls = win_ls;
        rec_we    = win_ls && ls_w;
        rec_addr  = win_ls ? ls_a : if_a;
        if (rec_we) begin
          ref_mem[rec_addr] = ls_d;
          rec_data = ls_d;
        end else begin
          rec_data = ref_mem[rec_addr];
        end
        last_ls = win_ls;
        next_ok = c + 2;
        if (win_ls) ls_pend = 0; else if_pend = 0;
      end
      next_cycle();
    end
    drive_idle();
    repeat (3) next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    proc_rst = 0;
    preload  = 0;
    bf.mem_out = 0;
    bp.mem_out = 0;
    drive_idle();
    test_reset();
    test_if_read();
    test_write_read();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    test_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
